// File: rtl/naive_bus_arbiter.sv
// naive_bus_arbiter: shares one single-ported naive_bus slave between m0 (fetch) and m1 (data/loader).
// Latency: request/grant paths are combinational; read data returns exactly 1 cycle after its grant.
// Backpressure: a withheld slave grant freezes winner state, so the same master is retried next cycle.
// Build option: define NAIVE_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority.
module naive_bus_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,

    // master port 0 (highest priority)
    input  logic        m0_rd_req,
    output logic        m0_rd_gnt,
    input  logic [31:0] m0_rd_addr,
    output logic [31:0] m0_rd_data,
    input  logic        m0_wr_req,
    output logic        m0_wr_gnt,
    input  logic [31:0] m0_wr_addr,
    input  logic [31:0] m0_wr_data,
    input  logic [3:0]  m0_wr_be,

    // master port 1
    input  logic        m1_rd_req,
    output logic        m1_rd_gnt,
    input  logic [31:0] m1_rd_addr,
    output logic [31:0] m1_rd_data,
    input  logic        m1_wr_req,
    output logic        m1_wr_gnt,
    input  logic [31:0] m1_wr_addr,
    input  logic [31:0] m1_wr_data,
    input  logic [3:0]  m1_wr_be,

    // downstream slave port
    output logic        s_rd_req,
    input  logic        s_rd_gnt,
    output logic [31:0] s_rd_addr,
    input  logic [31:0] s_rd_data,
    output logic        s_wr_req,
    input  logic        s_wr_gnt,
    output logic [31:0] s_wr_addr,
    output logic [31:0] s_wr_data,
    output logic [3:0]  s_wr_be
);

    // Which master the slave's next-cycle rd_data belongs to.
    typedef enum logic [1:0] {
        ROUTE_NONE = 2'd0,
        ROUTE_M0   = 2'd1,
        ROUTE_M1   = 2'd2
    } route_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);
    localparam logic [7:0] HOLD_SAT   = 8'hFF;

`ifdef NAIVE_ARB_ROUND_ROBIN_EN
    localparam logic ROUND_ROBIN = 1'b1;
`else
    localparam logic ROUND_ROBIN = 1'b0;
`endif

    // Winner-state and read-route registers.
    logic       last_q, last_d;
    logic [7:0] hold_q, hold_d;
    route_e     rd_route_q, rd_route_d;

    // Arbitration results.
    logic req0, req1, both_req, any_req;
    logic hold_hit;
    logic win;

    // Winner-side grant qualification.
    logic w_rd_gnt, w_wr_gnt, granted;

    // Pick the winner for this cycle from the requests, the hold counter and the policy.
    always_comb begin
        req0     = m0_rd_req | m0_wr_req;
        req1     = m1_rd_req | m1_wr_req;
        both_req = req0 & req1;
        // Reset suppresses every request toward the slave.
        any_req  = (req0 | req1) & ~rst;
        hold_hit = (hold_q >= HOLD_LIMIT);
        win      = 1'b0;
        if (both_req) begin
            if (hold_hit) begin
                // Hold limit overrides the policy: the master that has been waiting goes next.
                win = ~last_q;
            end else if (ROUND_ROBIN) begin
                win = ~last_q;
            end else begin
                win = 1'b0;
            end
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
    end

    // Forward the winner's read and write channels; drive zeros when nobody requests.
    always_comb begin
        s_rd_req  = 1'b0;
        s_rd_addr = 32'd0;
        s_wr_req  = 1'b0;
        s_wr_addr = 32'd0;
        s_wr_data = 32'd0;
        s_wr_be   = 4'd0;
        if (any_req) begin
            if (win) begin
                s_rd_req  = m1_rd_req;
                s_rd_addr = m1_rd_addr;
                s_wr_req  = m1_wr_req;
                s_wr_addr = m1_wr_addr;
                s_wr_data = m1_wr_data;
                s_wr_be   = m1_wr_be;
            end else begin
                s_rd_req  = m0_rd_req;
                s_rd_addr = m0_rd_addr;
                s_wr_req  = m0_wr_req;
                s_wr_addr = m0_wr_addr;
                s_wr_data = m0_wr_data;
                s_wr_be   = m0_wr_be;
            end
        end
    end

    // Return the slave's grants to the winner only; the loser never sees a grant.
    always_comb begin
        // s_*_req already carry the winner's request and are zero in reset.
        w_rd_gnt  = s_rd_gnt & s_rd_req;
        w_wr_gnt  = s_wr_gnt & s_wr_req;
        granted   = w_rd_gnt | w_wr_gnt;
        m0_rd_gnt = w_rd_gnt & ~win;
        m0_wr_gnt = w_wr_gnt & ~win;
        m1_rd_gnt = w_rd_gnt & win;
        m1_wr_gnt = w_wr_gnt & win;
    end

    // Next winner state and read route; an ungranted cycle leaves the winner state untouched.
    always_comb begin
        last_d     = last_q;
        hold_d     = hold_q;
        rd_route_d = ROUTE_NONE;
        if (granted) begin
            // A read and a write in the same cycle still count as a single transfer.
            if (win == last_q) begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 8'd1;
            end else begin
                hold_d = 8'd1;
                last_d = win;
            end
        end
        if (w_rd_gnt) begin
            rd_route_d = win ? ROUTE_M1 : ROUTE_M0;
        end
    end

    // State registers; last_q resets to m1 so m0 takes the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            hold_q     <= 8'd0;
            rd_route_q <= ROUTE_NONE;
        end else begin
            last_q     <= last_d;
            hold_q     <= hold_d;
            rd_route_q <= rd_route_d;
        end
    end

    // Steer the slave's late read data to the master granted last cycle; reset drops it.
    always_comb begin
        m0_rd_data = 32'd0;
        m1_rd_data = 32'd0;
        if (!rst) begin
            if (rd_route_q == ROUTE_M0) begin
                m0_rd_data = s_rd_data;
            end else if (rd_route_q == ROUTE_M1) begin
                m1_rd_data = s_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Bench for naive_bus_arbiter: slave model with 1-cycle read latency, scoreboard of expected read returns.
// Inputs change #1 after the rising edge; outputs are compared on the falling edge.
// Contention expectations follow the NAIVE_ARB_ROUND_ROBIN_EN setting of the build.
module tb_naive_bus_arbiter;

`ifdef NAIVE_ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_rd_req, m0_rd_gnt, m0_wr_req, m0_wr_gnt;
    logic [31:0] m0_rd_addr, m0_rd_data, m0_wr_addr, m0_wr_data;
    logic [3:0]  m0_wr_be;
    logic        m1_rd_req, m1_rd_gnt, m1_wr_req, m1_wr_gnt;
    logic [31:0] m1_rd_addr, m1_rd_data, m1_wr_addr, m1_wr_data;
    logic [3:0]  m1_wr_be;
    logic        s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
    logic [31:0] s_rd_addr, s_rd_data, s_wr_addr, s_wr_data;
    logic [3:0]  s_wr_be;
    logic        slv_rd_gnt, slv_wr_gnt;

    int checks   = 0;
    int failures = 0;

    // Expected {m0_rd_data, m1_rd_data} for the following cycle.
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;

    naive_bus_arbiter #(.HOLD_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .m0_rd_req(m0_rd_req), .m0_rd_gnt(m0_rd_gnt), .m0_rd_addr(m0_rd_addr), .m0_rd_data(m0_rd_data),
        .m0_wr_req(m0_wr_req), .m0_wr_gnt(m0_wr_gnt), .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data),
        .m0_wr_be(m0_wr_be),
        .m1_rd_req(m1_rd_req), .m1_rd_gnt(m1_rd_gnt), .m1_rd_addr(m1_rd_addr), .m1_rd_data(m1_rd_data),
        .m1_wr_req(m1_wr_req), .m1_wr_gnt(m1_wr_gnt), .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data),
        .m1_wr_be(m1_wr_be),
        .s_rd_req(s_rd_req), .s_rd_gnt(s_rd_gnt), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
        .s_wr_req(s_wr_req), .s_wr_gnt(s_wr_gnt), .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
        .s_wr_be(s_wr_be)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: rom = 32'h0000_6E33;
            32'h0000_0004: rom = 32'h0000_62B3;
            32'h0000_0008: rom = 32'h0003_02B7;
            default:       rom = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Slave model: grants on demand, returns read data one cycle after a granted read.
    assign s_rd_gnt = slv_rd_gnt;
    assign s_wr_gnt = slv_wr_gnt;
    always_ff @(posedge clk) begin
        s_rd_data <= (s_rd_req && s_rd_gnt) ? rom(s_rd_addr) : 32'h0BAD_0BAD;
    end

    task automatic idle_inputs();
        m0_rd_req = 0; m0_rd_addr = 0; m0_wr_req = 0; m0_wr_addr = 0; m0_wr_data = 0; m0_wr_be = 0;
        m1_rd_req = 0; m1_rd_addr = 0; m1_wr_req = 0; m1_wr_addr = 0; m1_wr_data = 0; m1_wr_be = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; idle_inputs(); slv_rd_gnt = 1; slv_wr_gnt = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        m0_rd_req = 1; m1_wr_req = 1; slv_rd_gnt = 1; slv_wr_gnt = 1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (m0_rd_gnt !== 1'b0) begin failures++; $display("FAIL rst_m0_rd_gnt got=%b exp=0", m0_rd_gnt); end
        checks++; if (m1_wr_gnt !== 1'b0) begin failures++; $display("FAIL rst_m1_wr_gnt got=%b exp=0", m1_wr_gnt); end
        checks++; if (s_rd_req !== 1'b0 || s_wr_req !== 1'b0) begin failures++; $display("FAIL rst_s_req got=%b%b exp=00", s_rd_req, s_wr_req); end
        checks++; if (m0_rd_data !== 32'd0 || m1_rd_data !== 32'd0) begin failures++; $display("FAIL rst_rd_data got=%h/%h exp=0/0", m0_rd_data, m1_rd_data); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dut.hold_q !== 8'd0) begin failures++; $display("FAIL rst_hold_q got=%0d exp=0", dut.hold_q); end
        checks++; if (dut.last_q !== 1'b1) begin failures++; $display("FAIL rst_last_q got=%b exp=1", dut.last_q); end
        checks++; if (dut.rd_route_q !== 2'd0) begin failures++; $display("FAIL rst_route got=%0d exp=0", dut.rd_route_q); end
        @(posedge clk); #1 rst = 0; idle_inputs();
    endtask

    task automatic test_single_read();
        logic [63:0] e;
        do_reset();
        @(posedge clk); #1;
        m0_rd_req = 1; m0_rd_addr = 32'h8;
        @(negedge clk);
        checks++; if (m0_rd_gnt !== 1'b1) begin failures++; $display("FAIL single_m0_rd_gnt got=%b exp=1", m0_rd_gnt); end
        checks++; if (m1_rd_gnt !== 1'b0) begin failures++; $display("FAIL single_m1_rd_gnt got=%b exp=0", m1_rd_gnt); end
        checks++; if (s_rd_addr !== 32'h8) begin failures++; $display("FAIL single_s_rd_addr got=%h exp=8", s_rd_addr); end
        sb_q.push_back({32'h0003_02B7, 32'h0});
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        e = sb_q.pop_front();
        checks++; if (m0_rd_data !== e[63:32]) begin failures++; $display("FAIL single_m0_rd_data got=%h exp=%h", m0_rd_data, e[63:32]); end
        checks++; if (m1_rd_data !== e[31:0]) begin failures++; $display("FAIL single_m1_rd_data got=%h exp=%h", m1_rd_data, e[31:0]); end
    endtask

    // Both masters read every cycle: RR alternates m0,m1; fixed priority gives 8 x m0 then 1 x m1.
    task automatic test_contention();
        logic [63:0] e;
        logic        exp_w;
        do_reset();
        for (int i = 0; i < 27; i++) begin
            @(posedge clk); #1;
            m0_rd_req = 1; m0_rd_addr = 32'h0; m1_rd_req = 1; m1_rd_addr = 32'h4;
            @(negedge clk);
            if (i > 0) begin
                e = sb_q.pop_front();
                checks++; if (m0_rd_data !== e[63:32]) begin failures++; $display("FAIL cont_m0_data cyc=%0d got=%h exp=%h", i, m0_rd_data, e[63:32]); end
                checks++; if (m1_rd_data !== e[31:0]) begin failures++; $display("FAIL cont_m1_data cyc=%0d got=%h exp=%h", i, m1_rd_data, e[31:0]); end
            end
            exp_w = RR_MODE ? 1'(i % 2) : ((i % 9) == 8);
            checks++; if (m0_rd_gnt !== ~exp_w) begin failures++; $display("FAIL cont_m0_gnt cyc=%0d got=%b exp=%b", i, m0_rd_gnt, ~exp_w); end
            checks++; if (m1_rd_gnt !== exp_w) begin failures++; $display("FAIL cont_m1_gnt cyc=%0d got=%b exp=%b", i, m1_rd_gnt, exp_w); end
            sb_q.push_back(exp_w ? {32'h0, 32'h0000_62B3} : {32'h0000_6E33, 32'h0});
        end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        e = sb_q.pop_front();
        checks++; if (m0_rd_data !== e[63:32] || m1_rd_data !== e[31:0]) begin failures++; $display("FAIL cont_tail got=%h/%h exp=%h/%h", m0_rd_data, m1_rd_data, e[63:32], e[31:0]); end
    endtask

    task automatic test_write();
        do_reset();
        @(posedge clk); #1;
        m1_wr_req = 1; m1_wr_addr = 32'h40; m1_wr_data = 32'hDEAD_BEEF; m1_wr_be = 4'hF;
        @(negedge clk);
        checks++; if (s_wr_req !== 1'b1) begin failures++; $display("FAIL wr_s_req got=%b exp=1", s_wr_req); end
        checks++; if (s_wr_addr !== 32'h40) begin failures++; $display("FAIL wr_s_addr got=%h exp=40", s_wr_addr); end
        checks++; if (s_wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_s_data got=%h exp=deadbeef", s_wr_data); end
        checks++; if (s_wr_be !== 4'hF) begin failures++; $display("FAIL wr_s_be got=%h exp=f", s_wr_be); end
        checks++; if (m1_wr_gnt !== 1'b1 || m0_wr_gnt !== 1'b0) begin failures++; $display("FAIL wr_gnt got=%b%b exp=10", m1_wr_gnt, m0_wr_gnt); end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        checks++; if (dut.hold_q !== 8'd1) begin failures++; $display("FAIL wr_hold_q got=%0d exp=1", dut.hold_q); end
        checks++; if (dut.last_q !== 1'b1) begin failures++; $display("FAIL wr_last_q got=%b exp=1", dut.last_q); end
    endtask

    // One m0 transfer primes last=m0/hold=1, then the slave stalls a contended read for 3 cycles.
    task automatic test_stall();
        logic [63:0] e;
        logic        exp_w;
        do_reset();
        @(posedge clk); #1;
        m0_rd_req = 1; m0_rd_addr = 32'h8;
        @(negedge clk);
        sb_q.push_back({32'h0003_02B7, 32'h0});
        exp_w = RR_MODE ? 1'b1 : 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            m0_rd_req = 1; m0_rd_addr = 32'h0; m1_rd_req = 1; m1_rd_addr = 32'h4;
            slv_rd_gnt = (i == 3);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++; if (m0_rd_data !== e[63:32] || m1_rd_data !== e[31:0]) begin failures++; $display("FAIL stall_data cyc=%0d got=%h/%h exp=%h/%h", i, m0_rd_data, m1_rd_data, e[63:32], e[31:0]); end
            checks++; if (s_rd_addr !== (exp_w ? 32'h4 : 32'h0)) begin failures++; $display("FAIL stall_winner cyc=%0d got=%h exp=%h", i, s_rd_addr, exp_w ? 32'h4 : 32'h0); end
            checks++; if (dut.hold_q !== 8'd1) begin failures++; $display("FAIL stall_hold_q cyc=%0d got=%0d exp=1", i, dut.hold_q); end
            checks++; if (m0_rd_gnt !== ((i == 3) && !exp_w) || m1_rd_gnt !== ((i == 3) && exp_w)) begin failures++; $display("FAIL stall_gnt cyc=%0d got=%b%b", i, m0_rd_gnt, m1_rd_gnt); end
            if (i == 3) sb_q.push_back(exp_w ? {32'h0, 32'h0000_62B3} : {32'h0000_6E33, 32'h0});
            else        sb_q.push_back(64'd0);
        end
        @(posedge clk); #1 idle_inputs(); slv_rd_gnt = 1;
        @(negedge clk);
        e = sb_q.pop_front();
        checks++; if (m0_rd_data !== e[63:32] || m1_rd_data !== e[31:0]) begin failures++; $display("FAIL stall_ret got=%h/%h exp=%h/%h", m0_rd_data, m1_rd_data, e[63:32], e[31:0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        m0_rd_req = 1; m0_rd_addr = 32'h8;
        @(negedge clk);
        checks++; if (m0_rd_gnt !== 1'b1) begin failures++; $display("FAIL rmid_gnt got=%b exp=1", m0_rd_gnt); end
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        checks++; if (m0_rd_data !== 32'd0) begin failures++; $display("FAIL rmid_m0_rd_data got=%h exp=0", m0_rd_data); end
        checks++; if (m0_rd_gnt !== 1'b0 || s_rd_req !== 1'b0) begin failures++; $display("FAIL rmid_req_gnt got=%b%b exp=00", m0_rd_gnt, s_rd_req); end
        @(posedge clk); #1 rst = 0; idle_inputs();
        @(negedge clk);
        checks++; if (dut.hold_q !== 8'd0 || dut.last_q !== 1'b1) begin failures++; $display("FAIL rmid_state got=%0d/%b exp=0/1", dut.hold_q, dut.last_q); end
        checks++; if (dut.rd_route_q !== 2'd0 || m0_rd_data !== 32'd0) begin failures++; $display("FAIL rmid_route got=%0d/%h exp=0/0", dut.rd_route_q, m0_rd_data); end
    endtask

    // Alternating single-master reads on consecutive cycles: each return follows its own grant.
    task automatic test_back_to_back();
        logic [63:0] e;
        logic [31:0] addr_tbl [5] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h0};
        logic        mst_tbl  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (i < 5) begin
                if (mst_tbl[i]) begin m1_rd_req = 1; m1_rd_addr = addr_tbl[i]; end
                else            begin m0_rd_req = 1; m0_rd_addr = addr_tbl[i]; end
            end
            @(negedge clk);
            if (i > 0) begin
                e = sb_q.pop_front();
                checks++; if (m0_rd_data !== e[63:32] || m1_rd_data !== e[31:0]) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h/%h exp=%h/%h", i, m0_rd_data, m1_rd_data, e[63:32], e[31:0]); end
            end
            if (i < 5) begin
                checks++; if (m1_rd_gnt !== mst_tbl[i] || m0_rd_gnt !== ~mst_tbl[i]) begin failures++; $display("FAIL b2b_gnt cyc=%0d got=%b%b", i, m1_rd_gnt, m0_rd_gnt); end
                sb_q.push_back(mst_tbl[i] ? {32'h0, rom(addr_tbl[i])} : {rom(addr_tbl[i]), 32'h0});
            end
        end
    endtask

    // A read and a write from m0 in one cycle are both forwarded and count once.
    task automatic test_rd_wr_same();
        logic [63:0] e;
        do_reset();
        @(posedge clk); #1;
        m0_rd_req = 1; m0_rd_addr = 32'h4; m0_wr_req = 1; m0_wr_addr = 32'h20; m0_wr_data = 32'h1234_5678; m0_wr_be = 4'h3;
        @(negedge clk);
        checks++; if (s_rd_req !== 1'b1 || s_wr_req !== 1'b1) begin failures++; $display("FAIL rw_s_req got=%b%b exp=11", s_rd_req, s_wr_req); end
        checks++; if (m0_rd_gnt !== 1'b1 || m0_wr_gnt !== 1'b1) begin failures++; $display("FAIL rw_gnt got=%b%b exp=11", m0_rd_gnt, m0_wr_gnt); end
        checks++; if (s_wr_data !== 32'h1234_5678 || s_wr_be !== 4'h3) begin failures++; $display("FAIL rw_wdata got=%h/%h exp=12345678/3", s_wr_data, s_wr_be); end
        sb_q.push_back({32'h0000_62B3, 32'h0});
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        e = sb_q.pop_front();
        checks++; if (m0_rd_data !== e[63:32] || m1_rd_data !== e[31:0]) begin failures++; $display("FAIL rw_data got=%h/%h exp=%h/%h", m0_rd_data, m1_rd_data, e[63:32], e[31:0]); end
        checks++; if (dut.hold_q !== 8'd1 || dut.last_q !== 1'b0) begin failures++; $display("FAIL rw_state got=%0d/%b exp=1/0", dut.hold_q, dut.last_q); end
    endtask

    initial begin
        slv_rd_gnt = 1; slv_wr_gnt = 1;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_rd_wr_same();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
